perceptron_neuron_controller: RTL and testbench
===============================================

Name: perceptron_neuron_controller

Overview:
Sequences one perceptron neuron evaluation over N_INPUTS weighted inputs. It reads input/weight pairs from external synchronous-read memories, multiplies them in 17.15 fixed point, and accumulates the products onto a bias with saturation. It then applies the piecewise-linear sigmoid (clamp to [0, 1.0]) and presents the result with a one-cycle valid pulse. It sits between the layer-level scheduler (start/ready) and the input/weight RAMs.

Parameters:
N_INPUTS, 8, number of input/weight pairs per evaluation (≥1)
ADDR_W, 3, memory address width; 2**ADDR_W ≥ N_INPUTS
FRAC, 15, fractional bits of the signed 32-bit fixed-point format; ONE = 1<<FRAC

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin evaluation; accepted only when ready=1
ready  out  1  high only in IDLE
bias  in  32  signed 17.15 bias; sampled on the accepted start edge
mem_rd  out  1  read strobe to input and weight RAMs
mem_addr  out  ADDR_W  shared read address for both RAMs
x_data  in  32  signed input word; valid the cycle after its mem_rd
w_data  in  32  signed weight word; valid the cycle after its mem_rd
y  out  32  signed activated result; holds until the next y_valid
y_valid  out  1  one-cycle pulse when y is updated
sat  out  1  sticky: a product or accumulation saturated during the current/last evaluation

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n). All state updates on the rising edge of clk.
- Reset (async, rst_n=0): state=IDLE, ready=1, mem_rd=0, mem_addr=0, y=0, y_valid=0, sat=0, acc=0, idx=0. Reset mid-evaluation abandons it; no y_valid is produced.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: ready=1. On start=1 at edge E0:
  - acc←bias, idx←0, sat←0, go to RUN.
  - start while not in IDLE is ignored, not queued.
- RUN, cycles 1..N_INPUTS:
  - mem_rd=1, mem_addr=idx; idx increments each cycle.
  - Leave for DRAIN after the cycle with idx=N_INPUTS-1.
- Pipeline: a registered rd_d (mem_rd delayed by one cycle) qualifies the data. On each cycle with rd_d=1, x_data*w_data is accumulated at the end of that cycle. Accumulation occurs on cycles 2..N_INPUTS+1.
- DRAIN (cycle N_INPUTS+1): mem_rd=0, mem_addr holds its last value, and the final product is accumulated. Next state DONE.
- DONE (cycle N_INPUTS+2):
  - y is registered from the activation of acc and is visible this cycle with y_valid=1.
  - Next state IDLE; ready=1 on cycle N_INPUTS+3.
  - Latency from start edge to y_valid: N_INPUTS+2 cycles.
- Arithmetic:
  - Full 64-bit signed product p = x*w, then arithmetic shift right by FRAC (floor toward −inf).
  - Saturate the shifted product to the 32-bit signed range.
  - Add to acc with 33-bit intermediate, then saturate to [0x80000000, 0x7FFFFFFF].
  - Any saturation sets sat=1; sat stays 1 until the next accepted start.
- Activation on final acc: y=0 if acc<0; y=ONE if acc>ONE; otherwise y=acc. acc=ONE exactly gives y=ONE.
- N_INPUTS=1: RUN lasts exactly one cycle; latency is 3.
- y and sat are not cleared at start; y retains the previous result until the next DONE.

Test Plan:
- Reset values: assert rst_n=0 asynchronously between edges -> all outputs take reset values immediately. Deassert, then start with N_INPUTS=4, bias=0, x[k]=0x4000, w[k]=0x8000 -> mem_rd high cycles 1–4 with addr 0,1,2,3; acc=0x10000; y=0x8000 with y_valid at cycle 6 only; ready=0 on cycles 1–6.
- Linear region: x[k]=0x1000, w[k]=0x8000, bias=0 -> y=0x4000, sat=0. Then bias=0x4000 with the same data -> y=0x8000 (exact ONE boundary).
- Negative clamp: bias=0xFFFF8000 (−1.0), x={0x8000,0,0,0}, w={0x4000,0,0,0} -> acc=0xFFFFC000, y=0. Also x=0xFFFFFFFF, w=0x8000 in one slot -> shifted product −1 (floor); check via acc.
- Saturation: x[0]=w[0]=0x7FFFFFFF, rest 0 -> product saturates to 0x7FFFFFFF, sat=1, y=0x8000. Next start with benign data -> sat returns to 0.
- Protocol: pulse start during RUN -> ignored, single y_valid. Pull rst_n low at cycle 3 -> no y_valid, ready=1 immediately. A fresh start then completes normally.
- Back-to-back: start held high continuously -> a new evaluation begins on the cycle ready returns (cycle 7 for N=4). y_valid pulses are spaced N+3 cycles apart.

Source files
------------

// File: rtl/perceptron_neuron_controller.sv
// rtl/perceptron_neuron_controller.sv - sequences one perceptron evaluation: fetch, 17.15 MAC with saturation, clamp activation
module perceptron_neuron_controller #(
    parameter int N_INPUTS = 8,
    parameter int ADDR_W   = 3,
    parameter int FRAC     = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     ready,
    input  logic signed [31:0]       bias,
    output logic                     mem_rd,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic signed [31:0]       x_data,
    input  logic signed [31:0]       w_data,
    output logic signed [31:0]       y,
    output logic                     y_valid,
    output logic                     sat
);

    localparam logic signed [31:0] ONE  = 32'sd1 <<< FRAC;
    localparam logic [ADDR_W-1:0]  LAST = ADDR_W'(N_INPUTS - 1);
    localparam logic signed [63:0] P_MAX = 64'sd2147483647;
    localparam logic signed [63:0] P_MIN = -64'sd2147483648;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state;
    logic               rd_d;
    logic signed [31:0] acc;

    logic signed [63:0] prod_full;
    logic signed [63:0] prod_shift;
    logic signed [31:0] prod_sat;
    logic               prod_ovf;
    logic [32:0]        sum;
    logic               add_ovf;
    logic signed [31:0] acc_next;

    // Clamp to [0, ONE]; acc exactly ONE passes through unchanged.
    function automatic logic signed [31:0] activate(input logic signed [31:0] a);
        if (a < 0)
            return 32'sd0;
        else if (a > ONE)
            return ONE;
        else
            return a;
    endfunction

    // Product, floor shift back to 17.15, saturate to 32 bits, then saturating add onto acc.
    always_comb begin
        prod_full  = x_data * w_data;
        prod_shift = prod_full >>> FRAC;
        prod_ovf   = 1'b0;
        prod_sat   = prod_shift[31:0];
        if (prod_shift > P_MAX) begin
            prod_sat = 32'sh7FFFFFFF;
            prod_ovf = 1'b1;
        end else if (prod_shift < P_MIN) begin
            prod_sat = 32'sh80000000;
            prod_ovf = 1'b1;
        end
        sum      = {acc[31], acc} + {prod_sat[31], prod_sat};
        add_ovf  = sum[32] ^ sum[31];
        acc_next = sum[31:0];
        if (add_ovf)
            acc_next = sum[32] ? 32'sh80000000 : 32'sh7FFFFFFF;
    end

    // Control FSM with registered outputs; rd_d marks cycles where RAM data is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ready    <= 1'b1;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            rd_d     <= 1'b0;
            acc      <= '0;
            y        <= '0;
            y_valid  <= 1'b0;
            sat      <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            rd_d    <= mem_rd;
            if (rd_d) begin
                acc <= acc_next;
                if (prod_ovf || add_ovf)
                    sat <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= bias;
                        sat      <= 1'b0;
                        mem_addr <= '0;
                        mem_rd   <= 1'b1;
                        ready    <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (mem_addr == LAST) begin
                        mem_rd <= 1'b0;
                        state  <= DRAIN;
                    end else begin
                        mem_addr <= mem_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    y       <= activate(acc_next);
                    y_valid <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_neuron_controller.sv
// tb/tb_perceptron_neuron_controller.sv - directed self-checking bench for perceptron_neuron_controller
module tb_perceptron_neuron_controller;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        ready;
    logic [31:0] bias = '0;
    logic        mem_rd;
    logic [1:0]  mem_addr;
    logic [31:0] x_data = '0;
    logic [31:0] w_data = '0;
    logic [31:0] y;
    logic        y_valid;
    logic        sat;

    logic [31:0] xm [4];
    logic [31:0] wm [4];

    int checks = 0;
    int failures = 0;

    logic        rd_log   [1:N+3];
    logic [1:0]  addr_log [1:N+3];
    logic        rdy_log  [1:N+3];
    int          vcount;
    int          vcycle;
    logic [31:0] got_y;
    logic        got_sat;

    perceptron_neuron_controller #(.N_INPUTS(N), .ADDR_W(2), .FRAC(15)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .bias(bias),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .x_data(x_data), .w_data(w_data),
        .y(y), .y_valid(y_valid), .sat(sat)
    );

    always #5 clk = ~clk;

    // synchronous-read RAM model shared by both memories
    always @(posedge clk) begin
        if (mem_rd) begin
            x_data <= xm[mem_addr];
            w_data <= wm[mem_addr];
        end
    end

    task automatic load(input logic [31:0] x0, x1, x2, x3, w0, w1, w2, w3);
        xm[0] = x0; xm[1] = x1; xm[2] = x2; xm[3] = x3;
        wm[0] = w0; wm[1] = w1; wm[2] = w2; wm[3] = w3;
    endtask

    task automatic run_eval(input logic [31:0] b);
        @(negedge clk);
        bias  = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        vcount = 0;
        vcycle = 0;
        got_y  = 'x;
        for (int c = 1; c <= N + 3; c++) begin
            @(negedge clk);
            rd_log[c]   = mem_rd;
            addr_log[c] = mem_addr;
            rdy_log[c]  = ready;
            if (y_valid) begin
                vcount++;
                vcycle = c;
                got_y  = y;
            end
            if (c == N + 2) got_sat = sat;
        end
    endtask

    task automatic test_reset;
        #12 rst_n = 1'b0;
        #1;
        checks++; if (ready !== 1'b1)    begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (mem_rd !== 1'b0)   begin failures++; $display("FAIL reset_mem_rd got=%b exp=0", mem_rd); end
        checks++; if (mem_addr !== 2'd0) begin failures++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
        checks++; if (y !== 32'h0)       begin failures++; $display("FAIL reset_y got=%h exp=0", y); end
        checks++; if (y_valid !== 1'b0)  begin failures++; $display("FAIL reset_y_valid got=%b exp=0", y_valid); end
        checks++; if (sat !== 1'b0)      begin failures++; $display("FAIL reset_sat got=%b exp=0", sat); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        load(32'h4000, 32'h4000, 32'h4000, 32'h4000, 32'h8000, 32'h8000, 32'h8000, 32'h8000);
        run_eval(32'h0);
        for (int c = 1; c <= N + 3; c++) begin
            checks++;
            if (rd_log[c] !== (c <= N)) begin
                failures++; $display("FAIL basic_mem_rd cycle=%0d got=%b exp=%b", c, rd_log[c], (c <= N));
            end
            if (c <= N) begin
                checks++;
                if (addr_log[c] !== 2'(c - 1)) begin
                    failures++; $display("FAIL basic_addr cycle=%0d got=%0d exp=%0d", c, addr_log[c], c - 1);
                end
            end
            checks++;
            if (rdy_log[c] !== (c == N + 3)) begin
                failures++; $display("FAIL basic_ready cycle=%0d got=%b exp=%b", c, rdy_log[c], (c == N + 3));
            end
        end
        checks++; if (vcount !== 1)       begin failures++; $display("FAIL basic_vcount got=%0d exp=1", vcount); end
        checks++; if (vcycle !== 6)       begin failures++; $display("FAIL basic_latency got=%0d exp=6", vcycle); end
        checks++; if (got_y !== 32'h8000) begin failures++; $display("FAIL basic_y got=%h exp=8000", got_y); end
        checks++; if (got_sat !== 1'b0)   begin failures++; $display("FAIL basic_sat got=%b exp=0", got_sat); end
        @(negedge clk);
        checks++; if (y !== 32'h8000)     begin failures++; $display("FAIL basic_y_hold got=%h exp=8000", y); end
    endtask

    task automatic test_linear;
        load(32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h8000, 32'h8000, 32'h8000, 32'h8000);
        run_eval(32'h0);
        checks++; if (got_y !== 32'h4000) begin failures++; $display("FAIL linear_y got=%h exp=4000", got_y); end
        checks++; if (got_sat !== 1'b0)   begin failures++; $display("FAIL linear_sat got=%b exp=0", got_sat); end
        run_eval(32'h4000);
        checks++; if (got_y !== 32'h8000) begin failures++; $display("FAIL linear_one_y got=%h exp=8000", got_y); end
    endtask

    task automatic test_negative;
        load(32'h8000, 32'h0, 32'h0, 32'h0, 32'h4000, 32'h0, 32'h0, 32'h0);
        run_eval(32'hFFFF8000);
        checks++; if (got_y !== 32'h0) begin failures++; $display("FAIL neg_clamp_y got=%h exp=0", got_y); end
        load(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h8000, 32'h1, 32'h0, 32'h0);
        run_eval(32'h100);
        checks++; if (got_y !== 32'hFE)  begin failures++; $display("FAIL floor_y got=%h exp=fe", got_y); end
        checks++; if (got_sat !== 1'b0) begin failures++; $display("FAIL floor_sat got=%b exp=0", got_sat); end
    endtask

    task automatic test_saturation;
        load(32'h7FFFFFFF, 32'h0, 32'h0, 32'h0, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h0);
        run_eval(32'h0);
        checks++; if (got_sat !== 1'b1)   begin failures++; $display("FAIL prod_sat got=%b exp=1", got_sat); end
        checks++; if (got_y !== 32'h8000) begin failures++; $display("FAIL prod_sat_y got=%h exp=8000", got_y); end
        checks++; if (sat !== 1'b1)       begin failures++; $display("FAIL sat_sticky got=%b exp=1", sat); end
        load(32'h10000, 32'h0, 32'h0, 32'h0, 32'h10000, 32'h0, 32'h0, 32'h0);
        run_eval(32'h7FFF0000);
        checks++; if (got_sat !== 1'b1)   begin failures++; $display("FAIL add_sat_pos got=%b exp=1", got_sat); end
        checks++; if (got_y !== 32'h8000) begin failures++; $display("FAIL add_sat_pos_y got=%h exp=8000", got_y); end
        load(32'hFFFF0000, 32'h0, 32'h0, 32'h0, 32'h10000, 32'h0, 32'h0, 32'h0);
        run_eval(32'h80010000);
        checks++; if (got_sat !== 1'b1)   begin failures++; $display("FAIL add_sat_neg got=%b exp=1", got_sat); end
        checks++; if (got_y !== 32'h0)    begin failures++; $display("FAIL add_sat_neg_y got=%h exp=0", got_y); end
        load(32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h8000, 32'h8000, 32'h8000, 32'h8000);
        run_eval(32'h0);
        checks++; if (got_sat !== 1'b0)   begin failures++; $display("FAIL sat_clear got=%b exp=0", got_sat); end
        checks++; if (got_y !== 32'h4000) begin failures++; $display("FAIL sat_clear_y got=%h exp=4000", got_y); end
    endtask

    task automatic test_protocol;
        int cnt;
        int first;
        load(32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h8000, 32'h8000, 32'h8000, 32'h8000);
        @(negedge clk);
        bias = 32'h0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cnt = 0; first = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (y_valid) begin
                cnt++;
                if (first == 0) first = c;
            end
            start = (c == 2);
        end
        start = 1'b0;
        checks++; if (cnt !== 1)   begin failures++; $display("FAIL ignore_start_count got=%0d exp=1", cnt); end
        checks++; if (first !== 6) begin failures++; $display("FAIL ignore_start_cycle got=%0d exp=6", first); end

        @(negedge clk);
        bias = 32'h0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ready !== 1'b1)  begin failures++; $display("FAIL midreset_ready got=%b exp=1", ready); end
        checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL midreset_mem_rd got=%b exp=0", mem_rd); end
        checks++; if (y !== 32'h0)     begin failures++; $display("FAIL midreset_y got=%h exp=0", y); end
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (y_valid) cnt++;
        end
        checks++; if (cnt !== 0) begin failures++; $display("FAIL midreset_no_valid got=%0d exp=0", cnt); end
        run_eval(32'h0);
        checks++; if (vcycle !== 6)       begin failures++; $display("FAIL fresh_latency got=%0d exp=6", vcycle); end
        checks++; if (got_y !== 32'h4000) begin failures++; $display("FAIL fresh_y got=%h exp=4000", got_y); end
    endtask

    task automatic test_back_to_back;
        int pulses[$];
        logic r7, r8;
        load(32'h4000, 32'h4000, 32'h4000, 32'h4000, 32'h8000, 32'h8000, 32'h8000, 32'h8000);
        @(negedge clk);
        bias = 32'h0; start = 1'b1;
        r7 = 1'b0; r8 = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (y_valid) pulses.push_back(c);
            if (c == 7) r7 = ready;
            if (c == 8) r8 = ready;
        end
        start = 1'b0;
        checks++; if (r7 !== 1'b1) begin failures++; $display("FAIL b2b_ready_c7 got=%b exp=1", r7); end
        checks++; if (r8 !== 1'b0) begin failures++; $display("FAIL b2b_ready_c8 got=%b exp=0", r8); end
        checks++;
        if (pulses.size() !== 2) begin
            failures++; $display("FAIL b2b_pulse_count got=%0d exp=2", pulses.size());
        end else begin
            checks++; if (pulses[0] !== 6)  begin failures++; $display("FAIL b2b_first got=%0d exp=6", pulses[0]); end
            checks++; if (pulses[1] !== 13) begin failures++; $display("FAIL b2b_second got=%0d exp=13", pulses[1]); end
        end
        for (int c = 0; c < 8; c++) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_linear();
        test_negative();
        test_saturation();
        test_protocol();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
